// File: rtl/rnn_ram_pkg.sv
// Purpose: shared types, defaults and a ceil-log2 helper for the RNN parameter bank RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rnn_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_e;

  localparam int NBANK_DEF = 5;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 512;

  // Address width needed to index 'value' entries; never less than 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rnn_ram_bank.sv
// Purpose: one DW x DEPTH storage bank with synchronous write and registered read.
// Latency: read data appears one cycle after re; write lands on the enabling edge.
// Backpressure: none; every enabled access is taken.
// Ports: clk/reset; we, waddr, wdata (write port); re, raddr (read port); rdata (read register,
//        cleared by reset, holds when re=0; a same-edge read of a written address sees old data).
module rnn_ram_bank
  import rnn_ram_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = clog2(DEPTH_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto a RAM macro; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rnn_param_bank_ram.sv
// Purpose: NBANK parallel parameter/state banks sharing one write and one read address, with clear engine.
// Latency: read returns rd_data/rd_valid one cycle after rd_en; clear takes DEPTH cycles (busy high).
// Backpressure: while busy, wr_en/rd_en/clr_req are dropped; clr_req in IDLE wins over same-cycle accesses.
// Ports: clk, reset (sync, active-high); clr_req, busy; wr_en[NBANK], wr_addr, wr_data[NBANK*DW];
//        rd_en, rd_addr, rd_data[NBANK*DW], rd_valid. Bank b uses slice [b*DW +: DW].
module rnn_param_bank_ram
  import rnn_ram_pkg::*;
#(
  parameter int  NBANK = NBANK_DEF,
  parameter int  DW    = DW_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  FWD   = 1,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_req,
  output logic                busy,
  input  logic [NBANK-1:0]    wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [NBANK*DW-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [NBANK*DW-1:0] rd_data,
  output logic                rd_valid
);

  localparam int            AW1     = AW + 1;
  localparam logic [AW:0]   DEPTH_L = AW1'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  ram_state_e    state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] bank_waddr;
  logic          clearing;
  logic          accept;
  logic          wr_in_rng;
  logic          rd_in_rng;
  logic          rd_go;
  logic          addr_eq;
  logic          oor_q;

  assign clearing   = (state == CLEAR);
  assign busy       = clearing;           // state is a register, so busy is too
  assign accept     = (state == IDLE) && !clr_req;
  assign wr_in_rng  = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_rng  = {1'b0, rd_addr} < DEPTH_L;
  assign rd_go      = accept && rd_en;
  assign addr_eq    = (wr_addr == rd_addr);
  assign bank_waddr = clearing ? clr_ptr : wr_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_ptr == LAST) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Pointer rests at 0 outside CLEAR so a new clear always starts from the bottom.
  always_ff @(posedge clk) begin
    if (reset || !clearing)  clr_ptr <= '0;
    else if (clr_ptr == LAST) clr_ptr <= '0;
    else                      clr_ptr <= clr_ptr + AW'(1);
  end

  // Out-of-range reads skip the banks and force zero at the output mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) oor_q <= !rd_in_rng;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic          we;
    logic [DW-1:0] wd;
    logic [DW-1:0] q;
    logic          fwd_hit;
    logic [DW-1:0] fwd_dat;

    assign we = clearing || (accept && wr_en[b] && wr_in_rng);
    assign wd = clearing ? '0 : wr_data[b*DW +: DW];

    rnn_ram_bank #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (bank_waddr),
      .wdata (wd),
      .re    (rd_go && rd_in_rng),
      .raddr (rd_addr),
      .rdata (q)
    );

    // The bank read sees pre-write data; capture the colliding write here to override it.
    always_ff @(posedge clk) begin
      if (reset) begin
        fwd_hit <= 1'b0;
        fwd_dat <= '0;
      end else if (rd_go) begin
        fwd_hit <= (FWD != 0) && wr_en[b] && addr_eq && rd_in_rng;
        fwd_dat <= wr_data[b*DW +: DW];
      end
    end

    assign rd_data[b*DW +: DW] = oor_q ? '0 : (fwd_hit ? fwd_dat : q);
  end

endmodule

// File: tb/tb_rnn_param_bank_ram.sv
// Purpose: randomized plus directed bench for rnn_param_bank_ram, two instances (512/FWD=1, 300/FWD=0).
// Latency: model updates on each rising edge; outputs compared on each falling edge.
// Backpressure: inputs shared by both instances; each model honours its own busy window.
module tb_rnn_param_bank_ram;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr_req;
  logic [4:0]   wr_en;
  logic [8:0]   wr_addr;
  logic [159:0] wr_data;
  logic         rd_en;
  logic [8:0]   rd_addr;

  logic         busy_a, rv_a, busy_b, rv_b;
  logic [159:0] rd_a, rd_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rnn_param_bank_ram #(.NBANK(5), .DW(32), .DEPTH(512), .FWD(1)) dut_a (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a), .rd_valid(rv_a)
  );

  rnn_param_bank_ram #(.NBANK(5), .DW(32), .DEPTH(300), .FWD(0)) dut_b (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b), .rd_valid(rv_b)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: a memory array, a remaining-busy count and the last read result.
  // A clear zeroes the whole array at once; accesses are ignored while the count runs down.
  logic [31:0]  m_mem [2][512][5];
  logic [159:0] m_rd  [2];
  bit           m_rv  [2];
  int           m_cnt [2];

  task automatic m_zero(input int i);
    for (int a = 0; a < 512; a++)
      for (int b = 0; b < 5; b++) m_mem[i][a][b] = 32'h0;
  endtask

  task automatic model_step(input int i);
    int d;
    bit f;
    d = (i == 0) ? 512 : 300;
    f = (i == 0);
    if (reset) begin
      m_cnt[i] = d; m_rv[i] = 1'b0; m_rd[i] = '0; m_zero(i);
    end else if (m_cnt[i] > 0) begin
      m_cnt[i]--; m_rv[i] = 1'b0;
    end else if (clr_req) begin
      m_cnt[i] = d; m_rv[i] = 1'b0; m_zero(i);
    end else begin
      m_rv[i] = rd_en;
      if (rd_en) begin
        for (int b = 0; b < 5; b++) begin
          if (int'(rd_addr) >= d)                      m_rd[i][b*32 +: 32] = 32'h0;
          else if (f && wr_en[b] && wr_addr == rd_addr) m_rd[i][b*32 +: 32] = wr_data[b*32 +: 32];
          else                                          m_rd[i][b*32 +: 32] = m_mem[i][rd_addr][b];
        end
      end
      if (int'(wr_addr) < d)
        for (int b = 0; b < 5; b++)
          if (wr_en[b]) m_mem[i][wr_addr][b] = wr_data[b*32 +: 32];
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_a",   {159'b0, busy_a}, {159'b0, m_cnt[0] > 0});
      check("rvalid_a", {159'b0, rv_a},   {159'b0, m_rv[0]});
      check("rdata_a",  rd_a,             m_rd[0]);
      check("busy_b",   {159'b0, busy_b}, {159'b0, m_cnt[1] > 0});
      check("rvalid_b", {159'b0, rv_b},   {159'b0, m_rv[1]});
      check("rdata_b",  rd_b,             m_rd[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; wr_en = '0; rd_en = 1'b0;
  endtask

  // Counts busy cycles of each instance until both are idle; also notes any rd_valid from A while busy.
  task automatic count_busy(output int na, output int nb, output bit saw_rv);
    na = 0; nb = 0; saw_rv = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy_a && !busy_b) break;
      if (busy_a) begin
        na++;
        if (rv_a) saw_rv = 1'b1;
      end
      if (busy_b) nb++;
      tick();
    end
  endtask

  task automatic do_read(input logic [8:0] a);
    rd_en = 1'b1; rd_addr = a; tick(); rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] en, input logic [8:0] a, input logic [159:0] d);
    wr_en = en; wr_addr = a; wr_data = d; tick(); wr_en = '0;
  endtask

  function automatic logic [8:0] pick_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 9'($urandom_range(0, 15));
      2:       return 9'($urandom_range(290, 311));
      default: return 9'($urandom_range(495, 511));
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int na, nb;
    bit saw;
    reset = 1'b1; idle_inputs(); wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    count_busy(na, nb, saw);
    check("reset_busy_len_a", 160'(na), 160'd512);
    check("reset_busy_len_b", 160'(nb), 160'd300);

    do_read(9'd0);
    check("zero_addr0_valid", {159'b0, rv_a}, 160'd1);
    check("zero_addr0_data",  rd_a, 160'd0);
    do_read(9'd255);
    check("zero_addr255_data", rd_a, 160'd0);
    do_read(9'd511);
    check("zero_addr511_valid", {159'b0, rv_a}, 160'd1);
    check("zero_addr511_b_valid", {159'b0, rv_b}, 160'd1);

    do_write(5'b00101, 9'd7, {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000});
    do_read(9'd7);
    check("partial_write", rd_a, {32'h0, 32'h0, 32'hA5A5_0002, 32'h0, 32'hA5A5_0000});

    do_write(5'b11111, 9'd9, {5{32'h11}});
    wr_en = 5'b11111; wr_addr = 9'd9; wr_data = {5{32'h22}};
    rd_en = 1'b1; rd_addr = 9'd9; tick(); idle_inputs();
    check("fwd1_new", rd_a, {5{32'h22}});
    check("fwd0_old", rd_b, {5{32'h11}});
    do_read(9'd9);
    check("fwd0_after", rd_b, {5{32'h22}});

    do_write(5'b11111, 9'd299, {5{32'h55}});
    do_write(5'b11111, 9'd300, {5{32'h55}});
    do_read(9'd299);
    check("d300_addr299", rd_b, {5{32'h55}});
    do_read(9'd300);
    check("d300_addr300_data",  rd_b, 160'd0);
    check("d300_addr300_valid", {159'b0, rv_b}, 160'd1);
    check("d512_addr300_data",  rd_a, {5{32'h55}});

    do_write(5'b11111, 9'd3, {5{32'hDEAD_BEEF}});
    wr_en = 5'b11111; wr_addr = 9'd3; wr_data = {5{32'h1234_5678}};
    rd_en = 1'b1; rd_addr = 9'd3; clr_req = 1'b1; tick(); idle_inputs();
    check("clr_no_valid", {159'b0, rv_a}, 160'd0);
    count_busy(na, nb, saw);
    check("clr_busy_len", 160'(na), 160'd512);
    check("clr_busy_rv",  {159'b0, saw}, 160'd0);
    do_read(9'd3);
    check("clr_addr3_zero", rd_a, 160'd0);

    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    reset = 1'b1; rd_en = 1'b1; rd_addr = 9'd5; tick(); reset = 1'b0;
    count_busy(na, nb, saw);
    rd_en = 1'b0;
    check("rst_mid_busy_len", 160'(na), 160'd512);
    check("rst_mid_rv",       {159'b0, saw}, 160'd0);

    for (int k = 0; k < 4000; k++) begin
      wr_en   = 5'($urandom_range(0, 31));
      wr_addr = pick_addr();
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : pick_addr();
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rd_en   = 1'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 1499) == 0);
      reset   = ($urandom_range(0, 2499) == 0);
      tick();
    end
    reset = 1'b0; idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
